// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the data-memory access unit.
// Holds the access-size and FSM state encodings plus the store byte-mask helper.
package mem_access_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [LANES-1:0] byte_mask(input size_t size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: byte_mask = 4'b0001 << lane;
      SZ_HALF: byte_mask = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: byte_mask = 4'b1111;
      default: byte_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load alignment: right-justifies the addressed byte/half of a memory word
// and sign- or zero-extends it to the full data width.
module load_align
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        lane,
  input  size_t             size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted = word >> {lane, 3'b000};
    data    = '0;
    case (size)
      SZ_BYTE: data = {{(DATA_W-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_HALF: data = {{(DATA_W-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
      SZ_WORD: data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data memory: byte/half/word stores in one cycle, fixed-latency
// extended loads with stall, error flagging and registered branch decision.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctrl_memRead,
  input  logic              ctrl_memWrite,
  input  logic [1:0]        ctrl_size,
  input  logic              ctrl_unsigned,
  input  logic              ctrl_branch,
  input  logic              zero,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] write_data_into_mem,
  output logic [DATA_W-1:0] read_data_from_mem,
  output logic              rd_valid,
  output logic              mem_stall,
  output logic              ctrl_pcSrc,
  output logic              misaligned,
  output logic [DATA_W-1:0] memory [DEPTH_WORDS]
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              pend_q;
  logic [IDX_W-1:0]  lat_idx;
  logic [1:0]        lat_lane;
  size_t             lat_size;
  logic              lat_uns;
  logic              lat_err;

  size_t             req_size;
  logic [1:0]        lane;
  logic [IDX_W-1:0]  idx;
  logic              req_err;
  logic              do_wr, do_rd, capture;
  logic [LANES-1:0]  wr_mask;
  logic [DATA_W-1:0] wr_lanes;
  logic [DATA_W-1:0] aligned;

  assign req_size = size_t'(ctrl_size);
  assign lane     = mem_address[1:0];
  assign idx      = mem_address[IDX_W+1:2];
  assign req_err  = (req_size == SZ_RSVD)
                  || (req_size == SZ_HALF && lane[0])
                  || (req_size == SZ_WORD && lane != 2'b00)
                  || (|(mem_address >> (IDX_W + 2)));

  // Requests are only honoured in IDLE; a simultaneous read+write keeps the write.
  assign do_wr   = (state_q == IDLE) && ctrl_memWrite;
  assign do_rd   = (state_q == IDLE) && ctrl_memRead && !ctrl_memWrite;
  assign capture = pend_q || (state_q == BUSY && cnt_q == '0);
  assign wr_mask = byte_mask(req_size, lane);

  always_comb begin
    case (req_size)
      SZ_BYTE: wr_lanes = {LANES{write_data_into_mem[7:0]}};
      SZ_HALF: wr_lanes = {2{write_data_into_mem[15:0]}};
      default: wr_lanes = write_data_into_mem;
    endcase
  end

  // Stall covers every cycle of the read except the final capture cycle,
  // so data follows stall release exactly as it does for single-cycle reads.
  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    case (state_q)
      IDLE: if (do_rd && RD_LAT > 1) state_d = BUSY;
      BUSY: begin
        mem_stall = (cnt_q != '0);
        if (cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .word        (memory[lat_idx]),
    .lane        (lat_lane),
    .size        (lat_size),
    .is_unsigned (lat_uns),
    .data        (aligned)
  );

  // stage p0: request sample / FSM and capture registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      pend_q             <= 1'b0;
      lat_idx            <= '0;
      lat_lane           <= '0;
      lat_size           <= SZ_BYTE;
      lat_uns            <= 1'b0;
      lat_err            <= 1'b0;
      read_data_from_mem <= '0;
      rd_valid           <= 1'b0;
      ctrl_pcSrc         <= 1'b0;
      misaligned         <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= do_rd && (RD_LAT == 1);
      rd_valid   <= capture;
      ctrl_pcSrc <= ctrl_branch && zero;
      misaligned <= (state_q == IDLE) && (ctrl_memRead || ctrl_memWrite)
                    && (req_err || (ctrl_memRead && ctrl_memWrite));
      if (do_rd) begin
        cnt_q    <= CNT_INIT;
        lat_idx  <= idx;
        lat_lane <= lane;
        lat_size <= req_size;
        lat_uns  <= ctrl_unsigned;
        lat_err  <= req_err;
      end else if (state_q == BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (capture) read_data_from_mem <= lat_err ? '0 : aligned;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) memory[i] <= '0;
    end else if (do_wr && !req_err) begin
      for (int l = 0; l < LANES; l++)
        if (wr_mask[l]) memory[idx][8*l +: 8] <= wr_lanes[8*l +: 8];
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor to the MIPS data-memory stage. It holds a byte-addressed, word-organised data memory and supports byte, half-word and word access, with sign or zero extension on loads.
- Reads have a configurable fixed latency. A stall output holds the pipeline while a read is outstanding. The unit also flags misaligned and out-of-range accesses.
- Sits between the EX/MEM and MEM/WB pipeline registers. It also registers the branch decision (pcSrc) back to the fetch stage.

Parameters:
- DATA_W, 32, data word width; must be 32 (byte lanes fixed at 4).
- ADDR_W, 32, byte address width.
- DEPTH_WORDS, 1024, number of memory words; power of two.
- RD_LAT, 1, read latency in cycles from request sample to rd_valid; legal range 1..8.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ctrl_memRead  in  1  load request, sampled at posedge
- ctrl_memWrite  in  1  store request, sampled at posedge
- ctrl_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved
- ctrl_unsigned  in  1  1 selects zero-extension on loads, 0 selects sign-extension
- ctrl_branch  in  1  branch instruction in MEM stage
- zero  in  1  ALU zero flag
- mem_address  in  ADDR_W  byte address
- write_data_into_mem  in  DATA_W  store data; the relevant bytes are taken from the low lanes
- read_data_from_mem  out  DATA_W  aligned, extended load result
- rd_valid  out  1  one-cycle pulse when read_data_from_mem updates
- mem_stall  out  1  high while a read is outstanding
- ctrl_pcSrc  out  1  registered ctrl_branch && zero
- misaligned  out  1  registered; current request was misaligned, reserved-size or out-of-range
- memory  out  DEPTH_WORDS x DATA_W  debug view of the array

Behaviour:
- Reset (async, high): all memory words cleared to 0. read_data_from_mem=0, rd_valid=0, mem_stall=0, ctrl_pcSrc=0, misaligned=0. FSM returns to IDLE and the latency counter is cleared. Reset asserted mid-read aborts the read: no rd_valid pulse is produced.
- Word index = mem_address[2+log2(DEPTH_WORDS)-1:2]. The byte lane is mem_address[1:0].
- Error conditions:
  - Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=0.
  - Out of range: mem_address >= DEPTH_WORDS*4.
  - Reserved size: ctrl_size=11.
  - Any error sets misaligned=1 for one cycle. A store under error writes nothing. A load under error still completes with its normal latency and returns 0.
- ctrl_pcSrc updates every cycle, independent of FSM state.
- FSM states: IDLE, BUSY.
  - IDLE + ctrl_memWrite: the store commits at this edge with a byte mask. Byte: 1 lane from wdata[7:0]. Half: lanes {1,0} or {3,2} from wdata[15:0]. Word: all lanes. Stores take one cycle with no stall.
  - IDLE + ctrl_memRead: latch the address, size and unsigned fields. The counter loads RD_LAT-1.
    - If RD_LAT=1: capture the data at the next edge and pulse rd_valid; mem_stall stays 0.
    - Else: go to BUSY with mem_stall=1.
  - BUSY: decrement the counter. At counter==0, capture the data from the latched address, pulse rd_valid, drop mem_stall and return to IDLE. ctrl_memRead and ctrl_memWrite are ignored while in BUSY.
  - Read and write asserted together in IDLE: the write commits, the read is dropped, and misaligned is pulsed.
- Load data:
  - The selected byte or half is right-justified.
  - Upper bits are sign-extended from bit 7 or 15 when ctrl_unsigned=0, zero-filled otherwise.
  - Word loads pass through unchanged.
- Read-after-write to the same word on consecutive cycles returns the new data, since the array is updated before the read capture edge.
- read_data_from_mem holds its value between rd_valid pulses.

Decomposition:
- Package mem_access_pkg:
  - size_t enum: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD.
  - state_t enum: IDLE, BUSY.
  - Function byte_mask(size, lane) returning 4 bits.
- One combinational sub-module, load_align: takes the word, lane, size and unsigned flag and returns the extended data. It is shared by the capture path.

Test Plan:
- Reset, then store word 0xDEADBEEF at 0x10, then load word at 0x10 (RD_LAT=1) -> rd_valid at the next edge, data 0xDEADBEEF, mem_stall never high.
- Store byte 0x80 at 0x13, then load byte at 0x13 with signed=1 -> 0xFFFFFF80; with unsigned=1 -> 0x00000080. memory[4] bits 31:24 = 0x80, other bytes unchanged.
- RD_LAT=4, load at 0x20 -> mem_stall high for 3 cycles and rd_valid on the 4th edge. A write pulsed during BUSY leaves memory[8] unchanged.
- Half store to 0x21 -> misaligned=1 for one cycle and memory[8] unchanged. Word load at address 4096 (DEPTH=1024) -> misaligned=1 and data 0.
- ctrl_branch=1, zero=1 -> ctrl_pcSrc=1 next cycle; zero=0 -> ctrl_pcSrc=0 next cycle, including while in BUSY.
- RD_LAT=4, assert reset 2 cycles into a read -> all outputs 0 immediately, no rd_valid pulse, memory cleared, next load works normally.
